// File: rtl/lf16_mp_sched_pkg.sv
// Shared types for the multi-precision add/sub scheduler.
package lf16_sched_pkg;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned NW_W   = 2;

    typedef logic [WORD_W-1:0] lf16_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/lf16_mp_sched_if.sv
// Request, response and external-adder signals of lf16_mp_sched.
interface lf16_mp_sched_if
    import lf16_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned MAXW = 4
);
    localparam int unsigned OPW = WORD_W * MAXW;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_a;
    logic [NREQ*OPW-1:0]  req_b;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ*NW_W-1:0] req_nw;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [OPW-1:0]       rsp_sum;
    logic                 rsp_cout;
    lf16_word_t           add_a;
    lf16_word_t           add_b;
    logic                 add_cin;
    lf16_word_t           add_s;
    logic                 add_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_nw, rsp_ready, add_s, add_cout,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, req_nw, rsp_ready, add_s, add_cout,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/lf16_mp_sched_rr_arb.sv
// Round-robin pick: first requester at or after i_ptr, wrapping at NREQ.
module rr_arb
    import lf16_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2
)
(
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_gnt_vld,
    output logic [ID_W-1:0] o_gnt_id
);
    localparam int unsigned CW     = ID_W + 1;
    localparam int unsigned MAXREQ = 1 << ID_W;

    logic [CW-1:0]     w_cand;
    logic [MAXREQ-1:0] w_req_x;

    assign w_req_x = MAXREQ'(i_req);

    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_id  = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = CW'(i_ptr) + CW'(k);
            if (w_cand >= CW'(NREQ)) begin
                w_cand = w_cand - CW'(NREQ);
            end
            if (!o_gnt_vld && w_req_x[w_cand[ID_W-1:0]]) begin
                o_gnt_vld = 1'b1;
                o_gnt_id  = w_cand[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/lf16_mp_sched.sv
// Arbitrates NREQ multi-precision add/sub requests onto one shared 16-bit
// adder, sequencing words LSW-first and chaining the carry between words.
module lf16_mp_sched
    import lf16_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned MAXW = 4
)
(
    input  logic            clk,
    input  logic            rst_n,
    lf16_mp_sched_if.slave  bus
);
    localparam int unsigned OPW    = WORD_W * MAXW;
    localparam int unsigned MAXREQ = 1 << ID_W;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ID_W-1:0]           r_ptr;
    logic [ID_W-1:0]           r_id;
    logic [NW_W-1:0]           r_idx;
    logic [NW_W-1:0]           r_nw;
    logic                      r_carry;
    logic                      r_sub;
    lf16_word_t [MAXW-1:0]     r_a;
    lf16_word_t [MAXW-1:0]     r_b;
    lf16_word_t [MAXW-1:0]     r_sum;
    logic                      w_gnt_vld;
    logic [ID_W-1:0]           w_gnt_id;
    logic [NW_W-1:0]           w_nw_raw;
    logic [NW_W-1:0]           w_nw_req;
    logic [MAXREQ-1:0]         w_sub_x;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    // Word count of the granted requester, clamped to the operand width
    assign w_nw_raw = bus.req_nw[32'(w_gnt_id)*NW_W +: NW_W];
    assign w_nw_req = (32'(w_nw_raw) > MAXW - 1) ? NW_W'(MAXW - 1) : w_nw_raw;
    assign w_sub_x  = MAXREQ'(bus.req_sub);

    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_cout  = r_carry;
    assign bus.rsp_id    = r_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = '0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        bus.add_cin   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    bus.req_ready = NREQ'(1) << w_gnt_id;
                    w_state_nxt   = RUN;
                end
            end
            RUN: begin
                bus.add_a   = r_a[r_idx];
                bus.add_b   = r_sub ? ~r_b[r_idx] : r_b[r_idx];
                bus.add_cin = (r_idx == '0) ? r_sub : r_carry;
                if (r_idx == r_nw) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-word result/carry update and pointer advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_idx   <= '0;
            r_nw    <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_a   <= bus.req_a[32'(w_gnt_id)*OPW +: OPW];
                        r_b   <= bus.req_b[32'(w_gnt_id)*OPW +: OPW];
                        r_sub <= w_sub_x[w_gnt_id];
                        r_nw  <= w_nw_req;
                        r_id  <= w_gnt_id;
                        r_sum <= '0;
                        r_idx <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= bus.add_s;
                    r_carry      <= bus.add_cout;
                    if (r_idx != r_nw) begin
                        r_idx <= r_idx + NW_W'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_ptr <= (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lf16_mp_sched.sv
// Self-checking bench for lf16_mp_sched with a behavioural 16-bit adder.
module tb_lf16_mp_sched;
    import lf16_sched_pkg::*;

    localparam int NREQ = 2;
    localparam int MAXW = 4;
    localparam int OPW  = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_ptr  = 0;
    logic [63:0] g_sum;
    logic        g_cout;

    lf16_mp_sched_if #(.NREQ(NREQ), .MAXW(MAXW)) bus ();

    lf16_mp_sched #(.NREQ(NREQ), .MAXW(MAXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign {bus.add_cout, bus.add_s} = 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_cin);

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [1:0]  nw;
        logic [63:0] es;
        logic        ec;
    } vec_t;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Reference: modular (nw+1)-word add/sub with the carry at bit 16*(nw+1)
    function automatic logic [64:0] ref_add(logic [63:0] a, logic [63:0] b, logic sub, int nw);
        logic [64:0] m;
        logic [64:0] bb;
        m  = (65'd1 << (16 * (nw + 1))) - 65'd1;
        bb = {1'b0, (sub ? ~b : b)} & m;
        return ({1'b0, a} & m) + bb + 65'(sub);
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] mask, int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [63:0] a, logic [63:0] b, logic sub, logic [1:0] nw);
        bus.req_a[i*OPW +: OPW] = a;
        bus.req_b[i*OPW +: OPW] = b;
        bus.req_sub[i]          = sub;
        bus.req_nw[i*2 +: 2]    = nw;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
        chk({tag, "_rsp_id"},    64'(bus.rsp_id),    0);
        chk({tag, "_rsp_cout"},  64'(bus.rsp_cout),  0);
        chk({tag, "_rsp_sum"},   bus.rsp_sum,        0);
        chk({tag, "_add_a"},     64'(bus.add_a),     0);
        chk({tag, "_add_b"},     64'(bus.add_b),     0);
        chk({tag, "_add_cin"},   64'(bus.add_cin),   0);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 0);
    endtask

    // One full transaction: grant, RUN, optional stall in DONE, handshake
    task automatic serve(logic [NREQ-1:0] mask, int stall);
        int          g;
        int          cyc;
        int          bad;
        int          enw;
        logic [63:0] ea, eb;
        logic        esub;
        logic [64:0] r, m;
        logic [3:0]  cin_log, cin_exp;
        logic [63:0] s_sum;
        logic [2:0]  s_id;
        logic        s_cout;
        g    = rr_pick(mask, m_ptr);
        ea   = bus.req_a[g*OPW +: OPW];
        eb   = bus.req_b[g*OPW +: OPW];
        esub = bus.req_sub[g];
        enw  = int'(bus.req_nw[g*2 +: 2]);
        bus.req_valid = mask;
        bus.rsp_ready = (stall == 0);
        #1;
        cyc = 0;
        while (bus.req_ready == '0 && cyc < 8) begin
            step;
            cyc++;
        end
        if (bus.req_ready == '0) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = '0;
            return;
        end
        chk("grant", 64'(bus.req_ready), 64'(1) << g);
        step;
        cyc = 0; bad = 0; cin_log = '0;
        while (!bus.rsp_valid && cyc < 8) begin
            if (cyc < 4) cin_log[cyc] = bus.add_cin;
            if (bus.req_ready != '0) bad++;
            step;
            cyc++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            bus.req_valid = '0;
            return;
        end
        chk("latency", 64'(cyc + 1), 64'(enw + 2));
        cin_exp = '0;
        for (int k = 0; k <= enw; k++) begin
            r = ref_add(ea, eb, esub, k - 1);
            cin_exp[k] = (k == 0) ? esub : r[16*k];
        end
        chk("cin_seq", 64'(cin_log), 64'(cin_exp));
        for (int s = 0; s < stall; s++) begin
            s_sum = bus.rsp_sum; s_id = bus.rsp_id; s_cout = bus.rsp_cout;
            if (bus.req_ready != '0) bad++;
            step;
            if (!bus.rsp_valid || bus.rsp_sum !== s_sum || bus.rsp_id !== s_id || bus.rsp_cout !== s_cout) bad++;
        end
        if (bus.req_ready != '0) bad++;
        chk("busy_hold", 64'(bad), 0);
        bus.rsp_ready = 1'b1;
        r = ref_add(ea, eb, esub, enw);
        m = (65'd1 << (16 * (enw + 1))) - 65'd1;
        g_sum  = bus.rsp_sum;
        g_cout = bus.rsp_cout;
        chk("rsp_sum",  bus.rsp_sum,         r[63:0] & m[63:0]);
        chk("rsp_cout", 64'(bus.rsp_cout),   64'(r[16*(enw+1)]));
        chk("rsp_id",   64'(bus.rsp_id),     64'(g));
        step;
        bus.req_valid = '0;
        chk("rsp_release", 64'(bus.rsp_valid), 0);
        m_ptr = (g + 1) % NREQ;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [7];
        int          acc_t [4];
        int          ids [4];
        int          n_acc, n_ids, cyc, bad;
        logic [1:0]  msk;

        tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 2'd0, 64'h0000_0000_0000_0000, 1'b1};
        tbl[1] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'd3, 64'h0001_0000_0000_0000, 1'b0};
        tbl[2] = '{64'h5, 64'h7, 1'b1, 2'd0, 64'h0000_0000_0000_FFFE, 1'b0};
        tbl[3] = '{64'h7, 64'h5, 1'b1, 2'd0, 64'h0000_0000_0000_0002, 1'b1};
        tbl[4] = '{64'hFFFF_FFFF_1234_8000, 64'h8000, 1'b0, 2'd1, 64'h0000_0000_1235_0000, 1'b0};
        tbl[5] = '{64'h0, 64'h1, 1'b1, 2'd2, 64'h0000_FFFF_FFFF_FFFF, 1'b0};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.req_nw    = '0;
        bus.rsp_ready = 1'b1;
        step;
        step;
        check_zero("reset");
        rst_n = 1'b1;
        m_ptr = 0;

        for (int i = 0; i < 7; i++) begin
            set_req(0, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].nw);
            serve(2'b01, 0);
            chk($sformatf("tbl%0d_sum", i),  g_sum,       tbl[i].es);
            chk($sformatf("tbl%0d_cout", i), 64'(g_cout), 64'(tbl[i].ec));
        end

        // Round-robin with both requesters held valid and no backpressure
        rst_n = 1'b0; step; rst_n = 1'b1;
        m_ptr = 0;
        set_req(0, 64'h10, 64'h1, 1'b0, 2'd0);
        set_req(1, 64'h20, 64'h2, 1'b0, 2'd0);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        n_acc = 0; n_ids = 0; cyc = 0;
        #1;
        while (cyc < 40 && n_ids < 4) begin
            if (bus.req_ready != '0 && n_acc < 4) begin acc_t[n_acc] = cyc; n_acc++; end
            if (bus.rsp_valid) begin ids[n_ids] = int'(bus.rsp_id); n_ids++; end
            step;
            cyc++;
        end
        bus.req_valid = '0;
        chk("rr_count", 64'(n_ids), 4);
        for (int k = 0; k < n_ids; k++) begin
            chk($sformatf("rr_id%0d", k), 64'(ids[k]), 64'(rr_pick(2'b11, m_ptr)));
            m_ptr = (rr_pick(2'b11, m_ptr) + 1) % NREQ;
        end
        for (int k = 0; k + 1 < n_acc; k++) begin
            chk($sformatf("rr_spacing%0d", k), 64'(acc_t[k+1] - acc_t[k]), 3);
        end
        step;

        // Backpressure: both valid, five stalled cycles in DONE
        set_req(0, 64'h1234_5678_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 2'd2);
        set_req(1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1, 2'd3);
        serve(2'b11, 5);

        // Reset in the middle of a 4-word operation
        set_req(1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 2'd3);
        bus.req_valid = 2'b10;
        #1;
        cyc = 0;
        while (bus.req_ready == '0 && cyc < 8) begin step; cyc++; end
        chk("mid_grant", 64'(bus.req_ready), 64'h2);
        step;
        bus.req_valid = '0;
        step;
        step;
        chk("mid_add_a", 64'(bus.add_a), 64'h5678);
        rst_n = 1'b0;
        step;
        check_zero("midrst");
        rst_n = 1'b1;
        m_ptr = 0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.rsp_valid) bad++;
            step;
        end
        chk("midrst_no_rsp", 64'(bad), 0);
        set_req(0, 64'h0000_0000_0001_0002, 64'h0000_0000_0003_0004, 1'b0, 2'd1);
        serve(2'b11, 0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            msk = 2'($urandom_range(1, 3));
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)));
            end
            serve(msk, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lf16_mp_sched.md
Name: lf16_mp_sched

Overview:
Shares one external 16-bit prefix adder (A, B, Cin -> S, Cout) between NREQ requesters. Each request is a multi-precision add or subtract of up to MAXW 16-bit words. The block arbitrates round-robin, latches the operands and sequences the words LSW-first through the adder, one word per cycle, chaining Cout into the next Cin. It then returns the full-width result on a valid/ready response port.

Parameters:
NREQ, 2, number of requesters (2..8)
MAXW, 4, maximum operand length in 16-bit words (1..4)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  one-hot accept pulse; a request is accepted when req_valid[i] & req_ready[i]
req_a  input  NREQ*16*MAXW  operand A per requester, requester i at bits [i*16*MAXW +: 16*MAXW]
req_b  input  NREQ*16*MAXW  operand B, same packing
req_sub  input  NREQ  1 = A-B, 0 = A+B
req_nw  input  NREQ*2  word count minus 1 (0..MAXW-1) per requester
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  3  index of the requester served
rsp_sum  output  16*MAXW  result; words above the word count are zero
rsp_cout  output  1  final carry (for subtract, 1 = no borrow)
add_a  output  16  adder A input
add_b  output  16  adder B input (B word, inverted when subtracting)
add_cin  output  1  adder carry-in
add_s  input  16  adder sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  adder carry-out

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, rr_ptr=0, idx=0, carry=0, sum register=0, rsp_valid=0, rsp_id=0, rsp_cout=0. req_ready is 0. add_a, add_b and add_cin are 0. Reset mid-operation abandons the operation with no response.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant the first valid requester at or after rr_ptr (circular).
  - req_ready[g]=1 combinationally in this cycle only.
  - Latch A, B, sub, nw and g. Clear the sum register, set idx=0, then go to RUN.
  - If no request is valid, stay in IDLE.
- RUN, one word per cycle:
  - add_a = A word[idx].
  - add_b = sub ? ~B word[idx] : B word[idx].
  - add_cin = (idx==0) ? sub : carry.
  - At the edge: sum word[idx] <= add_s and carry <= add_cout.
  - If idx==nw, go to DONE; otherwise idx <= idx+1.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- DONE:
  - rsp_valid=1, rsp_sum = sum register, rsp_cout = carry, rsp_id = g.
  - All response outputs are held stable until rsp_ready=1.
  - On the handshake edge: go to IDLE and set rr_ptr <= (g+1) mod NREQ.
  - req_ready stays 0 throughout DONE.
- Latency: accept at cycle T, RUN during T+1..T+nw+1, rsp_valid first high at T+nw+2. With rsp_ready tied high, back-to-back accepts are nw+3 cycles apart.
- Arithmetic is modulo 2^(16*(nw+1)). The overflow carry appears only on rsp_cout.
- A requester dropping req_valid before it is granted is legal and causes no accept.
- Request inputs are ignored while in RUN or DONE.
- nw > MAXW-1 is clamped to MAXW-1.
- Only one operation is in flight; there is no queueing.

Decomposition:
- Package lf16_sched_pkg holds WORD_W=16, the state enum {IDLE, RUN, DONE}, and an lf16_word_t typedef.
- One sub-module, rr_arb (NREQ-wide round-robin priority pick from a pointer), is used in IDLE.
- The adder stays outside the block; the bench instantiates it and ties add_* to it.

Test Plan:
1. Single 16-bit add: req0 A=0xFFFF, B=0x0001, nw=0, sub=0 -> rsp_sum[15:0]=0x0000, rsp_cout=1, rsp_id=0, rsp_valid at T+2.
2. 64-bit carry ripple: A=0x0000_FFFF_FFFF_FFFF, B=1, nw=3 -> rsp_sum=0x0001_0000_0000_0000, cout=0. add_cin must read 0,1,1,1 over the four RUN cycles.
3. Subtract: A=0x0005, B=0x0007, nw=0, sub=1 -> sum=0xFFFE, cout=0. Then A=7, B=5 -> sum=0x0002, cout=1.
4. Round-robin fairness: req0 and req1 held valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1. req_ready is never high in RUN or DONE.
5. Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stay stable, with no new accept. Result is released on the cycle rsp_ready=1.
6. Reset mid-RUN of a 4-word op: rst_n=0 for 1 cycle at idx=2 -> all outputs 0 next cycle, no rsp_valid. The next request completes normally with rsp_id following rr_ptr=0.
